// File: rtl/robot_motion_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// robot_motion_ctrl_pkg
// Shared definitions for the robot sprite motion controller and the graphics
// renderer: screen geometry, wall position, sprite size, the command opcode
// encoding and the motion FSM state encoding.
// -----------------------------------------------------------------------------
package robot_motion_ctrl_pkg;

  // Screen and scene geometry (pixels)
  localparam int unsigned DEF_MAX_X      = 32'd640;
  localparam int unsigned DEF_MAX_Y      = 32'd480;
  localparam int unsigned DEF_WALL_X_L   = 32'd30;
  localparam int unsigned DEF_WALL_X_R   = 32'd40;
  localparam int unsigned DEF_ROBOT_SIZE = 32'd16;

  // Command opcode carried on cmd_op
  typedef enum logic [1:0] {
    OP_LEFT  = 2'd0,
    OP_RIGHT = 2'd1,
    OP_UP    = 2'd2,
    OP_DOWN  = 2'd3
  } cmd_op_e;

  // Motion controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_CLEAN = 2'd2,
    ST_DONE  = 2'd3
  } motion_state_e;

endpackage

// File: rtl/robot_motion_ctrl_if.sv
// -----------------------------------------------------------------------------
// robot_motion_ctrl_if
// Command handshake bundle between a command source (master) and the motion
// controller (slave).
//   cmd_valid  : command offered
//   cmd_op     : move direction (left/right/up/down)
//   cmd_clean  : clean command, cmd_op and cmd_steps are ignored
//   cmd_steps  : number of frame steps for a move (0 is legal)
//   cmd_ready  : controller accepts a command this cycle
// -----------------------------------------------------------------------------
interface robot_motion_ctrl_if;
  import robot_motion_ctrl_pkg::*;

  logic       cmd_valid;
  cmd_op_e    cmd_op;
  logic       cmd_clean;
  logic [5:0] cmd_steps;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_clean,
    output cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_clean,
    input  cmd_steps,
    output cmd_ready
  );

endinterface

// File: rtl/robot_motion_ctrl_frame_tick.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Produces exactly one single-cycle tick per video frame, on the rising edge of
// the registered vertical-blank flag (pix_y >= MAX_Y). clk runs at twice the
// pixel rate, so vblank stays high for many cycles; only its rising edge ticks.
// After reset the generator must first see pix_y outside vblank before it can
// tick, so a reset released in the middle of vblank does not produce a tick.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   pix_y : current pixel row
//   tick  : registered one-cycle frame pulse
// -----------------------------------------------------------------------------
module frame_tick_gen #(
  parameter int unsigned MAX_Y = 32'd480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_y,
  output logic       tick
);

  localparam logic [9:0] MAX_Y_V = 10'(MAX_Y);

  logic vblank_s;
  logic vblank_d, vblank_q;
  logic armed_d, armed_q;
  logic tick_d, tick_q;

  assign vblank_s = (pix_y >= MAX_Y_V);

  // Next-state for the vblank sample, arm flag and tick pulse
  always_comb begin
    vblank_d = vblank_s;
    // Armed once a non-vblank row has been observed since reset
    armed_d  = armed_q | ~vblank_s;
    // Tick coincides with the first cycle of registered vblank being high
    tick_d   = vblank_s & ~vblank_q & armed_q;
  end

  // Registers for vblank sample, arm flag and tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q <= 1'b0;
      armed_q  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      vblank_q <= vblank_d;
      armed_q  <= armed_d;
      tick_q   <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/robot_motion_ctrl.sv
// -----------------------------------------------------------------------------
// robot_motion_ctrl
// Moves a square robot sprite one STEP per video frame according to accepted
// commands, refusing any step that would leave the screen or overlap the wall,
// and runs timed clean commands of CLEAN_FRAMES frames.
//   clock_50   : sole clock
//   reset_n    : asynchronous active-low reset
//   pix_x      : current pixel column (motion is frame-based, not used)
//   pix_y      : current pixel row, used for frame tick detection
//   cmd        : command handshake (slave side)
//   robot_x/y  : registered top-left sprite coordinate
//   busy       : high in every state except IDLE
//   blocked    : one-cycle pulse when a move is aborted by wall or edge
//   clean_done : one-cycle pulse when a clean command finishes
// -----------------------------------------------------------------------------
module robot_motion_ctrl
  import robot_motion_ctrl_pkg::*;
#(
  parameter int unsigned MAX_X        = DEF_MAX_X,
  parameter int unsigned MAX_Y        = DEF_MAX_Y,
  parameter int unsigned WALL_X_L     = DEF_WALL_X_L,
  parameter int unsigned WALL_X_R     = DEF_WALL_X_R,
  parameter int unsigned ROBOT_SIZE   = DEF_ROBOT_SIZE,
  parameter int unsigned STEP         = 32'd4,
  parameter int unsigned CLEAN_FRAMES = 32'd30,
  parameter int unsigned START_X      = 32'd100,
  parameter int unsigned START_Y      = 32'd200
) (
  input  logic                clock_50,
  input  logic                reset_n,
  input  logic [9:0]          pix_x,
  input  logic [9:0]          pix_y,
  robot_motion_ctrl_if.slave  cmd,
  output logic [9:0]          robot_x,
  output logic [9:0]          robot_y,
  output logic                busy,
  output logic                blocked,
  output logic                clean_done
);

  // Geometry in 11-bit signed form so a step past column/row 0 goes negative
  localparam logic signed [10:0] MAX_X_S  = 11'(MAX_X);
  localparam logic signed [10:0] MAX_Y_S  = 11'(MAX_Y);
  localparam logic signed [10:0] WALL_L_S = 11'(WALL_X_L);
  localparam logic signed [10:0] WALL_R_S = 11'(WALL_X_R);
  localparam logic signed [10:0] SIZE_S   = 11'(ROBOT_SIZE);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic [15:0]        CLEAN_LAST = 16'(CLEAN_FRAMES);
  localparam logic [9:0]         START_X_V  = 10'(START_X);
  localparam logic [9:0]         START_Y_V  = 10'(START_Y);

  motion_state_e      state_d, state_q;
  cmd_op_e            op_d, op_q;
  logic [9:0]         x_d, x_q;
  logic [9:0]         y_d, y_q;
  logic [15:0]        cnt_d, cnt_q;
  logic               blocked_d, blocked_q;
  logic               clean_done_d, clean_done_q;
  logic               ready_d, ready_q;
  logic               busy_d, busy_q;

  logic               frame_tick_s;
  logic signed [10:0] x_s, y_s, nx_s, ny_s;
  logic               step_refused_s;
  logic               unused_pix_x_s;

  assign unused_pix_x_s = ^pix_x;

  frame_tick_gen #(
    .MAX_Y (MAX_Y)
  ) u_frame_tick (
    .clk   (clock_50),
    .rst_n (reset_n),
    .pix_y (pix_y),
    .tick  (frame_tick_s)
  );

  // Candidate next position and the edge/wall legality check for it
  always_comb begin
    x_s  = signed'({1'b0, x_q});
    y_s  = signed'({1'b0, y_q});
    nx_s = x_s;
    ny_s = y_s;
    case (op_q)
      OP_LEFT:  nx_s = x_s - STEP_S;
      OP_RIGHT: nx_s = x_s + STEP_S;
      OP_UP:    ny_s = y_s - STEP_S;
      OP_DOWN:  ny_s = y_s + STEP_S;
      default: begin
        nx_s = x_s;
        ny_s = y_s;
      end
    endcase
    step_refused_s = (nx_s < 11'sd0)
                  || ((nx_s + SIZE_S) > MAX_X_S)
                  || (ny_s < 11'sd0)
                  || ((ny_s + SIZE_S) > MAX_Y_S)
                  || ((nx_s <= WALL_R_S) && ((nx_s + SIZE_S - 11'sd1) >= WALL_L_S));
  end

  // FSM next-state, position/counter updates and pulse generation
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    blocked_d    = 1'b0;
    clean_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          op_d = cmd.cmd_op;
          if (cmd.cmd_clean) begin
            cnt_d   = 16'd0;
            state_d = ST_CLEAN;
          end else if (cmd.cmd_steps == 6'd0) begin
            cnt_d   = 16'd0;
            state_d = ST_DONE;
          end else begin
            cnt_d   = {10'd0, cmd.cmd_steps};
            state_d = ST_MOVE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (frame_tick_s) begin
          if (step_refused_s) begin
            blocked_d = 1'b1;
            cnt_d     = 16'd0;
            state_d   = ST_DONE;
          end else begin
            x_d   = nx_s[9:0];
            y_d   = ny_s[9:0];
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_MOVE;
            end
          end
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_CLEAN: begin
        if (frame_tick_s) begin
          cnt_d = cnt_q + 16'd1;
          if ((cnt_q + 16'd1) == CLEAN_LAST) begin
            clean_done_d = 1'b1;
            cnt_d        = 16'd0;
            state_d      = ST_DONE;
          end else begin
            state_d = ST_CLEAN;
          end
        end else begin
          state_d = ST_CLEAN;
        end
      end
      ST_DONE: begin
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
    endcase
    // Handshake flags follow the state being entered so they are registered
    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
  end

  // FSM state register
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Position, command, counter and output flag registers
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      op_q         <= OP_LEFT;
      x_q          <= START_X_V;
      y_q          <= START_Y_V;
      cnt_q        <= 16'd0;
      blocked_q    <= 1'b0;
      clean_done_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      op_q         <= op_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      blocked_q    <= blocked_d;
      clean_done_q <= clean_done_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign robot_x       = x_q;
  assign robot_y       = y_q;
  assign busy          = busy_q;
  assign blocked       = blocked_q;
  assign clean_done    = clean_done_q;

endmodule
